// File: rtl/video_pkg.sv
// Shared constants and helpers for the YCbCr/RGB colour-space converters.
package video_pkg;
  localparam int K_RCR       = 359;
  localparam int K_GCB       = 88;
  localparam int K_GCR       = 183;
  localparam int K_BCB       = 454;
  localparam int C_OFFSET    = 128;
  localparam int C_ROUND     = 128;
  localparam int CSC_LATENCY = 4;

  // Clamp a signed 12-bit channel sum to the 8-bit range 0..255.
  function automatic logic [7:0] clamp8(input logic signed [11:0] v);
    if (v[11])              return 8'd0;
    else if (|v[10:8])      return 8'd255;
    else                    return v[7:0];
  endfunction

  function automatic logic out_of_range(input logic signed [11:0] v);
    return v[11] | (|v[10:8]);
  endfunction
endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift-register delay for video timing signals (DEPTH >= 1).
module sync_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/ycbcr2rgb.sv
// Full-range YCbCr 4:4:4 to RGB565, 4-stage pipeline, with per-frame clamp counter.
module ycbcr2rgb
  import video_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_hsync,
  input  logic             pre_frame_de,
  input  logic [7:0]       img_y,
  input  logic [7:0]       img_cb,
  input  logic [7:0]       img_cr,
  output logic             post_frame_vsync,
  output logic             post_frame_hsync,
  output logic             post_frame_de,
  output logic [4:0]       img_red,
  output logic [5:0]       img_green,
  output logic [4:0]       img_blue,
  output logic [CNT_W-1:0] frame_sat_cnt
);
  localparam logic signed [8:0]  OFS  = 9'(C_OFFSET);
  localparam logic signed [17:0] KRCR = 18'(K_RCR);
  localparam logic signed [17:0] KGCB = 18'(K_GCB);
  localparam logic signed [17:0] KGCR = 18'(K_GCR);
  localparam logic signed [17:0] KBCB = 18'(K_BCB);
  localparam logic signed [19:0] RND  = 20'(C_ROUND);
  localparam logic [CNT_W-1:0]   CMAX = '1;

  logic signed [8:0]  cb1, cr1;
  logic [7:0]         y1, y2;
  logic signed [17:0] p_rcr, p_gcb, p_gcr, p_bcb;
  logic signed [11:0] r3, g3, b3;
  logic [4:0]         r4, b4;
  logic [5:0]         g4;
  logic               sat4;

  logic signed [19:0] t_r, t_g, t_b, s_r, s_g, s_b;
  logic [7:0]         cl_r, cl_g, cl_b;

  always_comb begin
    t_r  = {{2{p_rcr[17]}}, p_rcr} + RND;
    t_g  = RND - {{2{p_gcb[17]}}, p_gcb} - {{2{p_gcr[17]}}, p_gcr};
    t_b  = {{2{p_bcb[17]}}, p_bcb} + RND;
    s_r  = t_r >>> 8;
    s_g  = t_g >>> 8;
    s_b  = t_b >>> 8;
    cl_r = clamp8(r3);
    cl_g = clamp8(g3);
    cl_b = clamp8(b3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cb1 <= '0; cr1 <= '0; y1 <= '0; y2 <= '0;
      p_rcr <= '0; p_gcb <= '0; p_gcr <= '0; p_bcb <= '0;
      r3 <= '0; g3 <= '0; b3 <= '0;
      r4 <= '0; g4 <= '0; b4 <= '0; sat4 <= 1'b0;
    end else begin
      cb1   <= $signed({1'b0, img_cb}) - OFS;
      cr1   <= $signed({1'b0, img_cr}) - OFS;
      y1    <= img_y;
      p_rcr <= cr1 * KRCR;
      p_gcb <= cb1 * KGCB;
      p_gcr <= cr1 * KGCR;
      p_bcb <= cb1 * KBCB;
      y2    <= y1;
      r3    <= $signed({4'b0, y2}) + s_r[11:0];
      g3    <= $signed({4'b0, y2}) + s_g[11:0];
      b3    <= $signed({4'b0, y2}) + s_b[11:0];
      r4    <= cl_r[7:3];
      g4    <= cl_g[7:2];
      b4    <= cl_b[7:3];
      sat4  <= out_of_range(r3) | out_of_range(g3) | out_of_range(b3);
    end
  end

  sync_delay #(.DEPTH(CSC_LATENCY), .WIDTH(3)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({pre_frame_vsync, pre_frame_hsync, pre_frame_de}),
    .dout ({post_frame_vsync, post_frame_hsync, post_frame_de})
  );

  // Data runs every cycle; only the visible outputs are blanked outside de.
  assign img_red   = post_frame_de ? r4 : 5'd0;
  assign img_green = post_frame_de ? g4 : 6'd0;
  assign img_blue  = post_frame_de ? b4 : 5'd0;

  logic             vs_d, vs_rise, inc;
  logic [CNT_W-1:0] run_cnt;

  assign vs_rise = post_frame_vsync & ~vs_d;
  assign inc     = post_frame_de & sat4;

  // A clamped pixel on the vsync edge cycle belongs to the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d          <= 1'b0;
      run_cnt       <= '0;
      frame_sat_cnt <= '0;
    end else begin
      vs_d <= post_frame_vsync;
      if (vs_rise) begin
        frame_sat_cnt <= run_cnt;
        run_cnt       <= inc ? CNT_W'(1) : '0;
      end else if (inc && run_cnt != CMAX) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end
endmodule
